// File: rtl/aes_iteratif_sifreleyici.sv
// AES-128 iterative encryption core, UNROLL rounds per clock, keys expanded on the fly.
// Ports: clk, rst (sync high); in_valid/in_ready + matris/anahtar in; out_valid/out_ready + sifreli out; mesgul busy.
module aes_iteratif_sifreleyici #(
  parameter int UNROLL = 1,
  parameter int NR     = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] matris,
  input  logic [127:0] anahtar,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] sifreli,
  output logic         mesgul
);

  if (NR != 10 || UNROLL < 1 || UNROLL > 10 || (10 % UNROLL) != 0) begin : g_bad_cfg
    $error("UNROLL must be one of 1, 2, 5, 10 and NR must be 10");
  end

  localparam logic [3:0] NR4 = 4'(NR);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // RotWord + SubWord + Rcon, then the running xor across the four words
  function automatic logic [127:0] key_exp(
    input logic [127:0] k,
    input logic [7:0]   rc
  );
    logic [31:0] t, w0, w1, w2, w3;
    t  = {SBOX[k[23:16]], SBOX[k[15:8]], SBOX[k[7:0]], SBOX[k[31:24]]};
    t  = t ^ {rc, 24'h0};
    w0 = k[127:96] ^ t;
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] aes_round(
    input logic [127:0] s,
    input logic [127:0] k,
    input logic         last
  );
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [31:0]  m;
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      b[i] = SBOX[s[127-8*i -: 8]];
    end
    // byte index = 4*col + row; row r rotates left by r columns
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        t[4*c+r] = b[4*((c+r)%4)+r];
      end
    end
    for (int c = 0; c < 4; c++) begin
      a0 = t[4*c];
      a1 = t[4*c+1];
      a2 = t[4*c+2];
      a3 = t[4*c+3];
      if (last) begin
        m = {a0, a1, a2, a3};
      end else begin
        m = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
             a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
             a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
             xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
      end
      o[127-32*c -: 32] = m ^ k[127-32*c -: 32];
    end
    return o;
  endfunction

  state_e       state_q, state_d;
  logic [127:0] st_q, st_d;
  logic [127:0] rk_q, rk_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [7:0]   rcon_q, rcon_d;
  logic [127:0] sif_q, sif_d;

  logic [127:0] ch_st, ch_rk;
  logic [7:0]   ch_rc;
  logic [3:0]   ch_rn;

  // UNROLL rounds chained combinationally; the final round of a block
  // always lands last in the chain because UNROLL divides 10
  always_comb begin
    ch_st = st_q;
    ch_rk = rk_q;
    ch_rc = rcon_q;
    ch_rn = rnd_q;
    for (int u = 0; u < UNROLL; u++) begin
      ch_rn = ch_rn + 4'd1;
      ch_rk = key_exp(ch_rk, ch_rc);
      ch_st = aes_round(ch_st, ch_rk, ch_rn == NR4);
      ch_rc = xt(ch_rc);
    end
  end

  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    rk_d    = rk_q;
    rnd_d   = rnd_q;
    rcon_d  = rcon_q;
    sif_d   = sif_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          st_d    = matris ^ anahtar;
          rk_d    = anahtar;
          rnd_d   = 4'd0;
          rcon_d  = 8'h01;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        st_d   = ch_st;
        rk_d   = ch_rk;
        rcon_d = ch_rc;
        rnd_d  = ch_rn;
        if (ch_rn == NR4) begin
          sif_d   = ch_st;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      st_q    <= '0;
      rk_q    <= '0;
      rnd_q   <= '0;
      rcon_q  <= '0;
      sif_q   <= '0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      rk_q    <= rk_d;
      rnd_q   <= rnd_d;
      rcon_q  <= rcon_d;
      sif_q   <= sif_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign mesgul    = (state_q == S_RUN);
  assign sifreli   = sif_q;

endmodule

// File: tb/tb_aes_iteratif_sifreleyici.sv
// Bench for aes_iteratif_sifreleyici: reference AES model, vectors, backpressure, reset, random traffic.
// Instances for UNROLL = 1, 2, 5, 10 share stimulus; instance 0 gets the full scoreboard.
module tb_aes_iteratif_sifreleyici;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  in_valid;
  logic                  out_ready;
  logic [127:0]          matris;
  logic [127:0]          anahtar;
  logic [3:0]            ir, ov, ms;
  logic [3:0][127:0]     sf;

  int checks = 0;
  int errors = 0;
  int accepts = 0;
  int xfers = 0;
  logic [127:0] q [$];
  logic [7:0]   sb [256];

  localparam logic [127:0] K_T1 = 128'h0;
  localparam logic [127:0] C_T1 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] K_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P_C1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C_B  = 128'h3925841d02dc09fbdc118597196a0b32;

  always #5 clk = ~clk;

  aes_iteratif_sifreleyici #(.UNROLL(1)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]),
    .matris(matris), .anahtar(anahtar), .out_valid(ov[0]),
    .out_ready(out_ready), .sifreli(sf[0]), .mesgul(ms[0]));
  aes_iteratif_sifreleyici #(.UNROLL(2)) u_d2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]),
    .matris(matris), .anahtar(anahtar), .out_valid(ov[1]),
    .out_ready(out_ready), .sifreli(sf[1]), .mesgul(ms[1]));
  aes_iteratif_sifreleyici #(.UNROLL(5)) u_d5 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]),
    .matris(matris), .anahtar(anahtar), .out_valid(ov[2]),
    .out_ready(out_ready), .sifreli(sf[2]), .mesgul(ms[2]));
  aes_iteratif_sifreleyici #(.UNROLL(10)) u_d10 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[3]),
    .matris(matris), .anahtar(anahtar), .out_valid(ov[3]),
    .out_ready(out_ready), .sifreli(sf[3]), .mesgul(ms[3]));

  // ---------------- reference model ----------------
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] v, input int k);
    return (v << k) | (v >> (8 - k));
  endfunction

  function automatic logic [127:0] aes_model(input logic [127:0] pt,
                                             input logic [127:0] key);
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [31:0]  w [44];
    logic [31:0]  tw;
    logic [7:0]   rc;
    logic [127:0] o;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tw = w[i-1];
      if (i % 4 == 0) begin
        tw = {sb[tw[23:16]], sb[tw[15:8]], sb[tw[7:0]], sb[tw[31:24]]}
             ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tw;
    end
    for (int i = 0; i < 16; i++)
      s[i%4][i/4] = pt[127-8*i -: 8] ^ key[127-8*i -: 8];
    for (int rd = 1; rd <= 10; rd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[r][c] = sb[s[r][(c+r)%4]];
      for (int c = 0; c < 4; c++) begin
        if (rd < 10) begin
          s[0][c] = gm(t[0][c], 8'h02) ^ gm(t[1][c], 8'h03) ^ t[2][c] ^ t[3][c];
          s[1][c] = t[0][c] ^ gm(t[1][c], 8'h02) ^ gm(t[2][c], 8'h03) ^ t[3][c];
          s[2][c] = t[0][c] ^ t[1][c] ^ gm(t[2][c], 8'h02) ^ gm(t[3][c], 8'h03);
          s[3][c] = gm(t[0][c], 8'h03) ^ t[1][c] ^ t[2][c] ^ gm(t[3][c], 8'h02);
        end else begin
          for (int r = 0; r < 4; r++) s[r][c] = t[r][c];
        end
        for (int r = 0; r < 4; r++)
          s[r][c] = s[r][c] ^ w[4*rd+c][31-8*r -: 8];
      end
    end
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i%4][i/4];
    return o;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, got, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b", nm, got, exp);
    end
  endtask

  task automatic chkn(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, got, exp);
    end
  endtask

  // Scoreboard on instance 0: sampled at negedge, i.e. the values that
  // the next rising edge will see.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
    end else begin
      if (ir[0] && ov[0]) chk1("ready_and_valid_exclusive", 1'b1, 1'b0);
      if (ov[0]) begin
        if (q.size() == 0) begin
          chk1("spurious_out_valid", ov[0], 1'b0);
        end else begin
          chk("out_data", sf[0], q[0]);
          if (out_ready) begin
            void'(q.pop_front());
            xfers++;
          end
        end
      end
      if (in_valid && ir[0]) begin
        q.push_back(aes_model(matris, anahtar));
        accepts++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [127:0] pt, input logic [127:0] key);
    int n;
    matris   = pt;
    anahtar  = key;
    in_valid = 1'b1;
    n = 0;
    while (!ir[0] && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) chk1("accept_timeout", ir[0], 1'b1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!ov[0] && n < 40) begin
      step();
      n++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    int lt [4];
    int ul [4];
    int x0, a0, sent, cyc;
    ul = '{1, 2, 5, 10};
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    matris = '0;
    anahtar = '0;
    build_sbox();

    chk("model_t1", aes_model(128'h0, K_T1), C_T1);
    chk("model_c1", aes_model(P_C1, K_C1), C_C1);
    chk("model_b", aes_model(P_B, K_B), C_B);

    step();
    step();
    chk1("rst_in_ready", ir[0], 1'b1);
    chk1("rst_out_valid", ov[0], 1'b0);
    chk1("rst_mesgul", ms[0], 1'b0);
    chk("rst_sifreli", sf[0], 128'h0);
    rst = 1'b0;
    step();

    // T1
    accept(128'h0, K_T1);
    chk1("t1_mesgul", ms[0], 1'b1);
    chk1("t1_in_ready_run", ir[0], 1'b0);
    wait_out(lat);
    chkn("t1_latency", lat, 10);
    chk("t1_result", sf[0], C_T1);
    release_out();
    chk1("t1_out_valid_drop", ov[0], 1'b0);
    chk1("t1_in_ready_back", ir[0], 1'b1);

    // T2 on every unroll factor
    accept(P_C1, K_C1);
    for (int i = 0; i < 4; i++) lt[i] = 0;
    for (int c = 1; c <= 12; c++) begin
      step();
      for (int i = 0; i < 4; i++)
        if (ov[i] && lt[i] == 0) lt[i] = c;
    end
    for (int i = 0; i < 4; i++) begin
      chkn($sformatf("t2_latency_u%0d", ul[i]), lt[i], 10 / ul[i]);
      chk($sformatf("t2_result_u%0d", ul[i]), sf[i], C_C1);
    end
    release_out();

    // T3 backpressure
    accept(P_B, K_B);
    wait_out(lat);
    chkn("t3_latency", lat, 10);
    for (int c = 0; c < 7; c++) begin
      chk("t3_hold_data", sf[0], C_B);
      chk1("t3_hold_valid", ov[0], 1'b1);
      chk1("t3_hold_in_ready", ir[0], 1'b0);
      step();
    end
    out_ready = 1'b1;
    chk1("t3_in_ready_at_release", ir[0], 1'b0);
    step();
    out_ready = 1'b0;
    chk1("t3_in_ready_after", ir[0], 1'b1);
    chk1("t3_out_valid_after", ov[0], 1'b0);

    // T4 inputs ignored while busy
    x0 = xfers;
    a0 = accepts;
    accept(P_C1, K_C1);
    step();
    step();
    for (int c = 0; c < 2; c++) begin
      matris   = {$urandom, $urandom, $urandom, $urandom};
      anahtar  = {$urandom, $urandom, $urandom, $urandom};
      in_valid = 1'b1;
      chk1("t4_busy", ms[0], 1'b1);
      step();
    end
    in_valid = 1'b0;
    wait_out(lat);
    chk("t4_result", sf[0], C_C1);
    release_out();
    step();
    step();
    chk1("t4_no_second_out", ov[0], 1'b0);
    chkn("t4_one_transfer", xfers - x0, 1);
    chkn("t4_one_accept", accepts - a0, 1);

    // T5 reset at rnd=4
    accept(P_C1, K_C1);
    for (int c = 0; c < 4; c++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk1("t5_out_valid", ov[0], 1'b0);
    chk("t5_sifreli", sf[0], 128'h0);
    chk1("t5_in_ready", ir[0], 1'b1);
    accept(128'h0, K_T1);
    wait_out(lat);
    chkn("t5_latency", lat, 10);
    chk("t5_t1_result", sf[0], C_T1);
    release_out();

    // T6 random traffic
    x0 = xfers;
    a0 = accepts;
    sent = 0;
    cyc = 0;
    while (sent < 100 && cyc < 20000) begin
      in_valid = $urandom_range(0, 1) == 1;
      if (in_valid) begin
        matris  = {$urandom, $urandom, $urandom, $urandom};
        anahtar = {$urandom, $urandom, $urandom, $urandom};
      end
      out_ready = $urandom_range(0, 3) != 0;
      if (in_valid && ir[0]) sent++;
      step();
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    cyc = 0;
    while (q.size() > 0 && cyc < 100) begin
      step();
      cyc++;
    end
    out_ready = 1'b0;
    chkn("t6_sent", sent, 100);
    chkn("t6_accepts", accepts - a0, 100);
    chkn("t6_transfers", xfers - x0, 100);
    chkn("t6_queue_empty", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
